cos_rr_scheduler: RTL and testbench
===================================

Name: cos_rr_scheduler

Overview:
- Shares one multi-cycle floating-point cosine CORDIC unit (start/done, 32-bit IEEE-754 angle in, result out) among NUM_REQ requesters, e.g. several custom-instruction slots or DMA-fed channels.
- Round-robin arbitration, one operation in flight, per-requester response handshake with backpressure.
- Watchdog aborts and resets a hung engine, then returns a NaN error response.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, angle/result width (single-precision float)
- MAX_LAT, 32, cycles to wait for cos_done before abort (must be >= 8)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous active-low reset (0 = reset)
- clk_en  in  1  global enable; 0 freezes all state and counters
- req_valid  in  NUM_REQ  per-requester request valid
- req_angle  in  NUM_REQ*DATA_W  packed angles, requester i at bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot accept pulse
- rsp_valid  out  NUM_REQ  one-hot response valid, held until accepted
- rsp_ready  in  NUM_REQ  per-requester response ready
- rsp_result  out  DATA_W  shared result bus, valid with any rsp_valid bit
- rsp_err  out  1  qualifies rsp_valid: 1 = timeout abort
- cos_clk_en  out  1  equals clk_en
- cos_reset  out  1  active-high engine reset
- cos_start  out  1  one-cycle start pulse to engine
- cos_angle  out  DATA_W  registered angle to engine
- cos_done  in  1  engine completion
- cos_result  in  DATA_W  engine result, sampled when cos_done=1

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE, rr pointer=0.
  - req_ready, rsp_valid, cos_start, rsp_err, rsp_result, cos_angle all 0.
  - cos_reset=1 while reset=0.
  - Mid-operation reset discards the in-flight request; no response is issued.
- clk_en=0: no state, pointer, counter or output register changes. cos_reset and cos_clk_en stay combinational.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid, grant the first asserted index at or after the pointer, wrapping modulo NUM_REQ.
  - Drive req_ready[g]=1 combinationally in that cycle; the handshake completes there.
  - Latch req_angle[g] into cos_angle, register g, go to ISSUE.
- ISSUE: cos_start=1 for exactly one cycle, clear the watchdog counter, go to WAIT.
- WAIT:
  - cos_done=1: capture cos_result into rsp_result, rsp_err=0, go to RESP.
  - Counter reaches MAX_LAT with no done: rsp_result=32'h7FC00000 (quiet NaN), rsp_err=1, cos_reset=1 for one cycle, go to RESP.
  - cos_done is ignored in every state except WAIT.
- RESP:
  - rsp_valid[g]=1; rsp_result and rsp_err stay stable until rsp_ready[g]=1.
  - On that edge: pointer=(g+1) mod NUM_REQ, go to IDLE.
  - rsp_ready on other bits is ignored.
- Latency: request accepted at edge T, cos_start high in cycle T+1. If the engine asserts done in cycle T+1+L, rsp_valid rises in cycle T+2+L.
- No new grant until the previous response is accepted; at most one outstanding operation.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 other operations.
- A requester may drop req_valid before it is granted; this is not an error.

Decomposition:
- Package cos_sched_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the quiet-NaN constant 32'h7FC00000;
  - the default DATA_W;
  - the watchdog counter width function clog2(MAX_LAT+1).
- One sub-module, rr_pick: combinational round-robin selector. Inputs are the request vector and pointer; outputs are a one-hot grant and its index. It is reusable by other shared CORDIC units (sine, atan).

Test Plan:
Benches use a behavioural engine stub: done 6 cycles after start, result = angle + 1.
- Single request: requester 0 sends 32'h3F800000 -> req_ready[0] pulse once, cos_start once with cos_angle=32'h3F800000, rsp_valid[0] 8 cycles after accept, rsp_result=32'h3F800001, rsp_err=0.
- All four requesters assert at once with angles 32'h00000000, 32'h3F000000, 32'h3F800000, 32'hBF800000, rsp_ready tied high -> grants in order 0,1,2,3 with matching results; then requester 1 re-asserts alone -> granted next.
- Backpressure: rsp_ready[2]=0 for 10 cycles -> rsp_valid[2] and rsp_result held constant, no new cos_start, requester 3 pending; release -> requester 3 granted on the next edge.
- Timeout: stub never asserts done -> after 32 WAIT cycles cos_reset pulses 1 cycle, rsp_valid set, rsp_result=32'h7FC00000, rsp_err=1; next request completes normally.
- clk_en=0 for 5 cycles during WAIT (stub also frozen) -> no state or counter change, no false timeout; resumes and completes.
- Reset (reset=0) asserted mid-WAIT -> all outputs 0 on the next edge, no response for the dropped request, pointer=0, spurious cos_done afterwards ignored.

Source files
------------

// File: rtl/cos_sched_pkg.sv
// Shared types and constants for the cosine-engine round-robin scheduler.
package cos_sched_pkg;

    // Scheduler FSM: grant a requester, start the engine, wait, hand back the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Single-precision quiet NaN returned when the engine is aborted.
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Default angle/result width (IEEE-754 single).
    localparam int DATA_W_DEF = 32;

    // Watchdog counter width able to hold 0..max_lat.
    function automatic int wd_cnt_width(input int max_lat);
        return $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/cos_rr_scheduler_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after
// the pointer, wrapping. Shared by the CORDIC front-end schedulers.
module rr_pick
    import cos_sched_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan N positions starting at the pointer; the first hit wins.
    always_comb begin
        int c;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = 0;
        for (int off = 0; off < N; off++) begin
            c = (int'(ptr) + off) % N;
            if (!any && req[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = c[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/cos_rr_scheduler.sv
// Round-robin front end sharing one multi-cycle cosine CORDIC engine among
// NUM_REQ requesters, with a watchdog that aborts a hung engine.
module cos_rr_scheduler
    import cos_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MAX_LAT = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clk_en,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_angle,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [DATA_W-1:0]           rsp_result,
    output logic                        rsp_err,
    output logic                        cos_clk_en,
    output logic                        cos_reset,
    output logic                        cos_start,
    output logic [DATA_W-1:0]           cos_angle,
    input  logic                        cos_done,
    input  logic [DATA_W-1:0]           cos_result
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = wd_cnt_width(MAX_LAT);

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [CNT_W-1:0]   wd_cnt;
    logic               abort_q;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Accept is offered only when the grant will actually be taken at this edge.
    assign req_ready  = (reset && clk_en && state == IDLE) ? pick_gnt : '0;
    assign gnt_onehot = NUM_REQ'(1) << gnt_idx;
    assign cos_clk_en = clk_en;
    // Engine is held in reset with the scheduler, and pulsed on a watchdog abort.
    assign cos_reset  = ~reset | abort_q;

    // Scheduler FSM with registered engine/response outputs and watchdog.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt_idx    <= '0;
            wd_cnt     <= '0;
            abort_q    <= 1'b0;
            cos_start  <= 1'b0;
            cos_angle  <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else if (clk_en) begin
            cos_start <= 1'b0;
            abort_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        cos_angle <= req_angle[int'(pick_idx) * DATA_W +: DATA_W];
                        gnt_idx   <= pick_idx;
                        cos_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (cos_done) begin
                        rsp_result <= cos_result;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= gnt_onehot;
                        state      <= RESP;
                    end else if (wd_cnt == CNT_W'(MAX_LAT - 1)) begin
                        // MAX_LAT wait cycles without done: abort the engine.
                        rsp_result <= DATA_W'(QNAN);
                        rsp_err    <= 1'b1;
                        abort_q    <= 1'b1;
                        rsp_valid  <= gnt_onehot;
                        state      <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready[gnt_idx]) begin
                        rsp_valid <= '0;
                        ptr       <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cos_rr_scheduler.sv
// Directed bench for cos_rr_scheduler with a behavioural engine stub
// (done 6 cycles after start, result = angle + 1).
module tb_cos_rr_scheduler;

    localparam int NR = 4;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              clk_en;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_angle;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready;
    logic [DW-1:0]     rsp_result;
    logic              rsp_err;
    logic              cos_clk_en;
    logic              cos_reset;
    logic              cos_start;
    logic [DW-1:0]     cos_angle;
    logic              cos_done;
    logic [DW-1:0]     cos_result;

    int errors = 0;
    int checks = 0;
    int n_start = 0;
    int n_snap;

    logic          hang = 1'b0;
    logic          spur_done = 1'b0;
    logic [DW-1:0] spur_res = '0;
    logic          stub_done = 1'b0;
    logic [DW-1:0] stub_res = '0;
    int            stub_cnt = 0;

    logic [31:0] exp_res [4];

    cos_rr_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .MAX_LAT(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .req_valid  (req_valid),
        .req_angle  (req_angle),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .cos_clk_en (cos_clk_en),
        .cos_reset  (cos_reset),
        .cos_start  (cos_start),
        .cos_angle  (cos_angle),
        .cos_done   (cos_done),
        .cos_result (cos_result)
    );

    always #5 clk = ~clk;

    assign cos_done   = stub_done | spur_done;
    assign cos_result = spur_done ? spur_res : stub_res;

    // Engine stub: frozen with cos_clk_en, cleared by cos_reset.
    always @(posedge clk) begin
        if (cos_clk_en) begin
            if (cos_reset) begin
                stub_cnt  <= 0;
                stub_done <= 1'b0;
            end else begin
                stub_done <= 1'b0;
                if (cos_start) begin
                    stub_cnt <= 5;
                    stub_res <= cos_angle + 32'd1;
                end else if (stub_cnt == 1) begin
                    stub_cnt  <= 0;
                    stub_done <= !hang;
                end else if (stub_cnt > 1) begin
                    stub_cnt <= stub_cnt - 1;
                end
            end
        end
    end

    // Count engine starts actually seen by the engine.
    always @(posedge clk) begin
        if (cos_start && cos_clk_en) n_start <= n_start + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic wait_req(input logic [NR-1:0] expv, input string tag);
        int n;
        n = 0;
        #1;
        while (req_ready == '0 && n < 60) begin
            tick();
            n++;
        end
        chk(tag, 32'(req_ready), 32'(expv));
    endtask

    task automatic wait_rsp(input logic [NR-1:0] expv, input string tag);
        int n;
        n = 0;
        while (rsp_valid == '0 && n < 60) begin
            tick();
            n++;
        end
        chk(tag, 32'(rsp_valid), 32'(expv));
    endtask

    initial begin
        exp_res[0] = 32'h0000_0001;
        exp_res[1] = 32'h3F00_0001;
        exp_res[2] = 32'h3F80_0001;
        exp_res[3] = 32'hBF80_0001;

        reset     = 1'b0;
        clk_en    = 1'b1;
        req_valid = '0;
        req_angle = '0;
        rsp_ready = '0;
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_cos_start", 32'(cos_start), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_rsp_result", rsp_result, 32'h0);
        chk("rst_cos_angle", cos_angle, 32'h0);
        chk("rst_cos_reset", 32'(cos_reset), 32'h1);
        chk("rst_cos_clk_en", 32'(cos_clk_en), 32'h1);
        reset = 1'b1;
        tick();
        chk("rel_cos_reset", 32'(cos_reset), 32'h0);

        // Single request, fixed latency
        req_angle[0*DW +: DW] = 32'h3F80_0000;
        req_valid = 4'b0001;
        wait_req(4'b0001, "single_grant");
        tick();
        req_valid = '0;
        chk("single_start", 32'(cos_start), 32'h1);
        chk("single_angle", cos_angle, 32'h3F80_0000);
        chk("single_ready_drop", 32'(req_ready), 32'h0);
        repeat (6) tick();
        chk("single_early", 32'(rsp_valid), 32'h0);
        tick();
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_result", rsp_result, 32'h3F80_0001);
        chk("single_err", 32'(rsp_err), 32'h0);
        chk("single_nstart", 32'(n_start), 32'd1);
        rsp_ready = 4'b0001;
        tick();
        chk("single_rsp_clear", 32'(rsp_valid), 32'h0);
        rsp_ready = '0;

        // Re-reset so the pointer starts at 0 again
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // All four at once, rsp_ready tied high
        req_angle[0*DW +: DW] = 32'h0000_0000;
        req_angle[1*DW +: DW] = 32'h3F00_0000;
        req_angle[2*DW +: DW] = 32'h3F80_0000;
        req_angle[3*DW +: DW] = 32'hBF80_0000;
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        for (int g = 0; g < NR; g++) begin
            wait_req(NR'(1) << g, "rr_grant");
            tick();
            req_valid[g] = 1'b0;
            wait_rsp(NR'(1) << g, "rr_rsp_valid");
            chk("rr_result", rsp_result, exp_res[g]);
            tick();
        end
        req_angle[1*DW +: DW] = 32'h3F00_0000;
        req_valid = 4'b0010;
        wait_req(4'b0010, "reassert_grant");
        tick();
        req_valid = '0;
        wait_rsp(4'b0010, "reassert_rsp");
        chk("reassert_result", rsp_result, 32'h3F00_0001);
        tick();

        // Backpressure on requester 2; other ready bits high but ignored
        rsp_ready = 4'b1011;
        req_valid = 4'b1100;
        wait_req(4'b0100, "bp_grant");
        tick();
        req_valid = 4'b1000;
        wait_rsp(4'b0100, "bp_rsp");
        n_snap = n_start;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid", 32'(rsp_valid), 32'h4);
            chk("bp_hold_result", rsp_result, 32'h3F80_0001);
            chk("bp_no_ready", 32'(req_ready), 32'h0);
        end
        chk("bp_no_start", 32'(n_start), 32'(n_snap));
        rsp_ready = 4'b0100;
        tick();
        chk("bp_next_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        wait_rsp(4'b1000, "bp_r3_rsp");
        chk("bp_r3_result", rsp_result, 32'hBF80_0001);
        rsp_ready = 4'b1000;
        tick();
        rsp_ready = '0;

        // Watchdog timeout
        hang = 1'b1;
        req_angle[0*DW +: DW] = 32'h4000_0000;
        req_valid = 4'b0001;
        wait_req(4'b0001, "to_grant");
        tick();
        req_valid = '0;
        chk("to_start", 32'(cos_start), 32'h1);
        repeat (32) tick();
        chk("to_early_valid", 32'(rsp_valid), 32'h0);
        chk("to_early_creset", 32'(cos_reset), 32'h0);
        tick();
        chk("to_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("to_creset", 32'(cos_reset), 32'h1);
        chk("to_result", rsp_result, 32'h7FC0_0000);
        chk("to_err", 32'(rsp_err), 32'h1);
        tick();
        chk("to_creset_pulse", 32'(cos_reset), 32'h0);
        chk("to_hold_valid", 32'(rsp_valid), 32'h1);
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = '0;
        hang = 1'b0;
        req_angle[1*DW +: DW] = 32'h3F80_0000;
        req_valid = 4'b0010;
        wait_req(4'b0010, "after_to_grant");
        tick();
        req_valid = '0;
        wait_rsp(4'b0010, "after_to_rsp");
        chk("after_to_result", rsp_result, 32'h3F80_0001);
        chk("after_to_err", 32'(rsp_err), 32'h0);
        rsp_ready = 4'b0010;
        tick();
        rsp_ready = '0;

        // clk_en freeze during WAIT
        req_angle[2*DW +: DW] = 32'h3E80_0000;
        req_valid = 4'b0100;
        wait_req(4'b0100, "ce_grant");
        tick();
        req_valid = '0;
        repeat (3) tick();
        clk_en = 1'b0;
        #1;
        chk("ce_cos_clk_en", 32'(cos_clk_en), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ce_frozen_valid", 32'(rsp_valid), 32'h0);
        end
        clk_en = 1'b1;
        repeat (3) tick();
        chk("ce_early", 32'(rsp_valid), 32'h0);
        tick();
        chk("ce_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("ce_result", rsp_result, 32'h3E80_0001);
        chk("ce_err", 32'(rsp_err), 32'h0);
        rsp_ready = 4'b0100;
        tick();
        rsp_ready = '0;

        // Reset in the middle of WAIT
        req_angle[3*DW +: DW] = 32'h3F80_0000;
        req_valid = 4'b1000;
        wait_req(4'b1000, "mr_grant");
        tick();
        req_valid = '0;
        n_snap = n_start + 1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("mr_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mr_cos_start", 32'(cos_start), 32'h0);
        chk("mr_rsp_result", rsp_result, 32'h0);
        chk("mr_cos_angle", cos_angle, 32'h0);
        chk("mr_cos_reset", 32'(cos_reset), 32'h1);
        reset = 1'b1;
        tick();
        spur_done = 1'b1;
        spur_res  = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_spur_valid", 32'(rsp_valid), 32'h0);
            chk("mr_spur_result", rsp_result, 32'h0);
        end
        spur_done = 1'b0;
        chk("mr_nstart", 32'(n_start), 32'(n_snap));
        req_valid = 4'b1001;
        wait_req(4'b0001, "mr_ptr0_grant");
        tick();
        req_valid = '0;
        wait_rsp(4'b0001, "mr_after_rsp");
        chk("mr_after_result", rsp_result, 32'h4000_0001);
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
